// File: rtl/scan_tap_responder_if.sv
// Scan-chain port bundle between the chain controller (master) and the
// device-side TAP responder (slave).
interface scan_tap_responder_if;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       rtck;
    logic [7:0] i_pins;
    logic [7:0] o_pins;

    modport master (
        output tck, tms, tdi, i_pins,
        input  tdo, rtck, o_pins
    );

    modport slave (
        input  tck, tms, tdi, i_pins,
        output tdo, rtck, o_pins
    );
endinterface

// File: rtl/scan_tap_responder.sv
// JTAG TAP responder running entirely in the clk domain. tck/tms/tdi are
// oversampled, so tck is never used as a clock. It provides IDCODE, BYPASS
// and an 8-bit boundary data register.
module scan_tap_responder #(
    parameter logic [31:0] IDCODE      = 32'h1000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    scan_tap_responder_if.slave  bus
);

    localparam logic [3:0] INSTR_IDCODE = 4'h1;
    localparam logic [3:0] INSTR_SAMPLE = 4'h2;
    localparam logic [3:0] INSTR_EXTEST = 4'h3;
    localparam logic [3:0] IR_CAPTURE   = 4'b0101;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tapState_e;

    typedef enum logic [1:0] {DR_ID, DR_BOUNDARY, DR_BYPASS} drSel_e;

    logic [SYNC_STAGES-1:0] tckSync_q, tmsSync_q, tdiSync_q;
    logic                   prevTck_q;
    logic                   sTck, sTms, sTdi;
    logic                   tckRise, tckFall;

    tapState_e   state_q, state_d;
    logic [3:0]  ir_q, ir_d;
    logic [3:0]  irShift_q, irShift_d;
    logic [31:0] idShift_q, idShift_d;
    logic [7:0]  bsrShift_q, bsrShift_d;
    logic        bypass_q, bypass_d;
    logic [7:0]  oPins_q, oPins_d;
    logic        tdo_q, tdo_d;
    drSel_e      drSel;
    logic        drLsb;

    always_ff @(posedge clk) begin
        if (reset) begin
            tckSync_q <= '0;
            tmsSync_q <= '0;
            tdiSync_q <= '0;
            prevTck_q <= 1'b0;
        end else begin
            tckSync_q <= {tckSync_q[SYNC_STAGES-2:0], bus.tck};
            tmsSync_q <= {tmsSync_q[SYNC_STAGES-2:0], bus.tms};
            tdiSync_q <= {tdiSync_q[SYNC_STAGES-2:0], bus.tdi};
            prevTck_q <= sTck;
        end
    end

    assign sTck    = tckSync_q[SYNC_STAGES-1];
    assign sTms    = tmsSync_q[SYNC_STAGES-1];
    assign sTdi    = tdiSync_q[SYNC_STAGES-1];
    assign tckRise = sTck & ~prevTck_q;
    assign tckFall = ~sTck & prevTck_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tckRise) begin
            case (state_q)
                TLR:      state_d = sTms ? TLR    : RTI;
                RTI:      state_d = sTms ? SEL_DR : RTI;
                SEL_DR:   state_d = sTms ? SEL_IR : CAP_DR;
                CAP_DR:   state_d = sTms ? EX1_DR : SH_DR;
                SH_DR:    state_d = sTms ? EX1_DR : SH_DR;
                EX1_DR:   state_d = sTms ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_d = sTms ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_d = sTms ? UPD_DR : SH_DR;
                UPD_DR:   state_d = sTms ? SEL_DR : RTI;
                SEL_IR:   state_d = sTms ? TLR    : CAP_IR;
                CAP_IR:   state_d = sTms ? EX1_IR : SH_IR;
                SH_IR:    state_d = sTms ? EX1_IR : SH_IR;
                EX1_IR:   state_d = sTms ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_d = sTms ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_d = sTms ? UPD_IR : SH_IR;
                UPD_IR:   state_d = sTms ? SEL_DR : RTI;
                default:  state_d = TLR;
            endcase
        end
    end

    // SAMPLE and EXTEST share the boundary register; unknown codes fall to BYPASS
    always_comb begin
        case (ir_q)
            INSTR_IDCODE:               drSel = DR_ID;
            INSTR_SAMPLE, INSTR_EXTEST: drSel = DR_BOUNDARY;
            default:                    drSel = DR_BYPASS;
        endcase
        case (drSel)
            DR_ID:       drLsb = idShift_q[0];
            DR_BOUNDARY: drLsb = bsrShift_q[0];
            default:     drLsb = bypass_q;
        endcase
    end

    always_comb begin
        ir_d       = ir_q;
        irShift_d  = irShift_q;
        idShift_d  = idShift_q;
        bsrShift_d = bsrShift_q;
        bypass_d   = bypass_q;
        oPins_d    = oPins_q;
        tdo_d      = tdo_q;

        if (tckRise) begin
            case (state_q)
                CAP_IR: irShift_d = IR_CAPTURE;
                SH_IR:  irShift_d = {sTdi, irShift_q[3:1]};
                CAP_DR: begin
                    case (drSel)
                        DR_ID:       idShift_d  = IDCODE;
                        DR_BOUNDARY: bsrShift_d = bus.i_pins;
                        default:     bypass_d   = 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (drSel)
                        DR_ID:       idShift_d  = {sTdi, idShift_q[31:1]};
                        DR_BOUNDARY: bsrShift_d = {sTdi, bsrShift_q[7:1]};
                        default:     bypass_d   = sTdi;
                    endcase
                end
                default: ;
            endcase
        end

        // Output and update happen on the falling edge so the controller sees stable tdo at its next rise
        if (tckFall) begin
            case (state_q)
                SH_IR:   tdo_d = irShift_q[0];
                SH_DR:   tdo_d = drLsb;
                default: tdo_d = 1'b0;
            endcase
            if (state_q == UPD_IR) begin
                ir_d = irShift_q;
            end
            if (state_q == UPD_DR && ir_q == INSTR_EXTEST) begin
                oPins_d = bsrShift_q;
            end
        end

        if (state_q == TLR) begin
            ir_d    = INSTR_IDCODE;
            oPins_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q       <= INSTR_IDCODE;
            irShift_q  <= '0;
            idShift_q  <= '0;
            bsrShift_q <= '0;
            bypass_q   <= 1'b0;
            oPins_q    <= '0;
            tdo_q      <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            irShift_q  <= irShift_d;
            idShift_q  <= idShift_d;
            bsrShift_q <= bsrShift_d;
            bypass_q   <= bypass_d;
            oPins_q    <= oPins_d;
            tdo_q      <= tdo_d;
        end
    end

    assign bus.tdo    = tdo_q;
    assign bus.rtck   = prevTck_q;
    assign bus.o_pins = oPins_q;

endmodule

// File: tb/tb_scan_tap_responder.sv
// Bench for scan_tap_responder: table vectors, randomized scans against a
// transaction-level model, and hand-written TLR / reset / rtck sequences.
module tb_scan_tap_responder;

    localparam logic [31:0] IDCODE = 32'h1000_0001;
    localparam int          HALF   = 5;

    typedef struct {
        logic        doIr;
        logic [3:0]  ir;
        logic [7:0]  pins;
        logic [63:0] data;
        int          nBits;
        int          pauseAt;
        logic [63:0] expTdo;
        logic [7:0]  expOpins;
    } vector_t;

    logic clk;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;
    logic [7:0] oModel;
    vector_t    vectors [9];

    scan_tap_responder_if bus ();

    scan_tap_responder #(.IDCODE(IDCODE), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic tckRise(input logic tmsV, input logic tdiV, output logic tdoV);
        bus.tms = tmsV;
        bus.tdi = tdiV;
        repeat (HALF) @(negedge clk);
        tdoV = bus.tdo;
        bus.tck = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tckFall();
        bus.tck = 1'b0;
    endtask

    task automatic tckCycle(input logic tmsV, input logic tdiV, output logic tdoV);
        tckRise(tmsV, tdiV, tdoV);
        tckFall();
    endtask

    // From Run-Test/Idle through an IR scan back to Run-Test/Idle
    task automatic irScan(input logic [3:0] ir, output logic [3:0] cap);
        logic d;
        logic b;
        tckCycle(1'b1, 1'b0, d);
        tckCycle(1'b1, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        for (int i = 0; i < 4; i++) begin
            tckCycle(i == 3, ir[i], b);
            cap[i] = b;
        end
        tckCycle(1'b1, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
    endtask

    // From Run-Test/Idle to Update-DR, leaving tck high inside Update-DR
    task automatic drScanToUpdate(input int n, input logic [63:0] data, input int pauseAt,
                                  output logic [63:0] tdoBits);
        logic d;
        logic b;
        logic exitNow;
        tdoBits = '0;
        tckCycle(1'b1, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        for (int i = 0; i < n; i++) begin
            exitNow = (i == n - 1) || (pauseAt != 0 && i == pauseAt - 1);
            tckCycle(exitNow, data[i], b);
            tdoBits[i] = b;
            if (exitNow && i != n - 1) begin
                tckCycle(1'b0, 1'b0, d);
                tckCycle(1'b0, 1'b0, d);
                tckCycle(1'b0, 1'b0, d);
                tckCycle(1'b1, 1'b0, d);
                tckCycle(1'b0, 1'b0, d);
            end
        end
        tckRise(1'b1, 1'b0, d);
    endtask

    task automatic applyStimulus(input vector_t v, input string tag, input logic [7:0] oldPins);
        logic [3:0]  cap;
        logic [63:0] tdoBits;
        logic        d;
        bus.i_pins = v.pins;
        if (v.doIr) begin
            irScan(v.ir, cap);
            checkOutput({tag, " ir capture"}, cap, 4'h5);
        end
        drScanToUpdate(v.nBits, v.data, v.pauseAt, tdoBits);
        checkOutput({tag, " tdo"}, tdoBits, v.expTdo);
        checkOutput({tag, " o_pins before update fall"}, bus.o_pins, oldPins);
        tckFall();
        repeat (4) @(negedge clk);
        checkOutput({tag, " o_pins after update"}, bus.o_pins, v.expOpins);
        tckCycle(1'b0, 1'b0, d);
    endtask

    // Serial view of a DR scan: captured bits leave first, then tdi re-emerges delayed by the DR length
    function automatic int drLength(input logic [3:0] ir);
        if (ir == 4'h1) return 32;
        if (ir == 4'h2 || ir == 4'h3) return 8;
        return 1;
    endfunction

    function automatic logic [63:0] modelTdo(input logic [3:0] ir, input logic [7:0] pins,
                                             input logic [63:0] data, input int n);
        logic [31:0] cap;
        logic [63:0] res;
        int          len;
        len = drLength(ir);
        if (ir == 4'h1) cap = IDCODE;
        else if (len == 8) cap = {24'h0, pins};
        else cap = '0;
        res = '0;
        for (int k = 0; k < n; k++) begin
            if (k < len) res[k] = cap[k];
            else res[k] = data[k - len];
        end
        return res;
    endfunction

    function automatic logic [7:0] modelBoundary(input logic [7:0] pins, input logic [63:0] data, input int n);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            if (n + j < 8) b[j] = pins[n + j];
            else b[j] = data[n + j - 8];
        end
        return b;
    endfunction

    initial begin
        vector_t    v;
        logic [7:0] prevO;
        logic [7:0] newO;
        logic [3:0] cap;
        logic       d;
        int         n;

        vectors[0] = '{1'b0, 4'h1, 8'h00, 64'h0,   32, 0, 64'h1000_0001,    8'h00};
        vectors[1] = '{1'b1, 4'hF, 8'h00, 64'hD,   4,  0, 64'hA,            8'h00};
        vectors[2] = '{1'b1, 4'h2, 8'hA5, 64'h0,   8,  0, 64'hA5,           8'h00};
        vectors[3] = '{1'b1, 4'h3, 8'h5A, 64'h3C,  8,  0, 64'h5A,           8'h3C};
        vectors[4] = '{1'b1, 4'h2, 8'hFF, 64'h12,  8,  0, 64'hFF,           8'h3C};
        vectors[5] = '{1'b1, 4'h3, 8'h0F, 64'hC3,  8,  4, 64'h0F,           8'hC3};
        vectors[6] = '{1'b1, 4'h7, 8'h66, 64'h1,   2,  0, 64'h2,            8'hC3};
        vectors[7] = '{1'b1, 4'h1, 8'h00, 64'hAB,  40, 0, 64'hAB_1000_0001, 8'hC3};
        vectors[8] = '{1'b1, 4'h3, 8'h00, 64'hABC, 12, 0, 64'hC00,          8'hAB};

        reset      = 1'b1;
        bus.tck    = 1'b0;
        bus.tms    = 1'b1;
        bus.tdi    = 1'b0;
        bus.i_pins = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset tdo", bus.tdo, 1'b0);
        checkOutput("reset rtck", bus.rtck, 1'b0);
        checkOutput("reset o_pins", bus.o_pins, 8'h00);

        bus.tck = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rtck rise lag 2", bus.rtck, 1'b0);
        @(negedge clk);
        checkOutput("rtck rise lag 3", bus.rtck, 1'b1);
        bus.tck = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rtck fall lag 2", bus.rtck, 1'b1);
        @(negedge clk);
        checkOutput("rtck fall lag 3", bus.rtck, 1'b0);
        repeat (HALF) @(negedge clk);
        tckCycle(1'b0, 1'b0, d);

        $display("[TB] table vectors");
        prevO = 8'h00;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i], $sformatf("vec%0d", i), prevO);
            prevO = vectors[i].expOpins;
        end
        oModel = prevO;

        $display("[TB] randomized scans");
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 4))
                0:       v.ir = 4'h1;
                1:       v.ir = 4'h2;
                2:       v.ir = 4'h3;
                3:       v.ir = 4'hF;
                default: v.ir = 4'($urandom_range(0, 15));
            endcase
            n         = int'($urandom_range(1, 40));
            v.doIr    = 1'b1;
            v.pins    = 8'($urandom);
            v.data    = {$urandom, $urandom};
            v.nBits   = n;
            v.pauseAt = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : 0;
            v.expTdo  = modelTdo(v.ir, v.pins, v.data, n);
            newO      = (v.ir == 4'h3) ? modelBoundary(v.pins, v.data, n) : oModel;
            v.expOpins = newO;
            applyStimulus(v, $sformatf("rand%0d", it), oModel);
            oModel = newO;
        end

        $display("[TB] five tms=1 from Shift-DR");
        irScan(4'h3, cap);
        checkOutput("tlr ir capture", cap, 4'h5);
        bus.i_pins = 8'h99;
        tckCycle(1'b1, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        tckCycle(1'b0, 1'b1, d);
        repeat (5) tckCycle(1'b1, 1'b0, d);
        repeat (4) @(negedge clk);
        checkOutput("tlr o_pins", bus.o_pins, 8'h00);
        checkOutput("tlr tdo", bus.tdo, 1'b0);
        tckCycle(1'b0, 1'b0, d);
        v = '{1'b0, 4'h1, 8'h00, 64'h0, 32, 0, 64'(IDCODE), 8'h00};
        applyStimulus(v, "tlr idcode", 8'h00);

        $display("[TB] reset during Shift-DR");
        v = '{1'b1, 4'h3, 8'h00, 64'h81, 8, 0, 64'h00, 8'h81};
        applyStimulus(v, "pre-reset extest", 8'h00);
        bus.i_pins = 8'hFF;
        tckCycle(1'b1, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        tckCycle(1'b0, 1'b0, d);
        repeat (3) tckCycle(1'b0, 1'b0, d);
        repeat (4) @(negedge clk);
        checkOutput("pre-reset tdo", bus.tdo, 1'b1);
        checkOutput("pre-reset o_pins", bus.o_pins, 8'h81);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid-scan reset tdo", bus.tdo, 1'b0);
        checkOutput("mid-scan reset o_pins", bus.o_pins, 8'h00);
        checkOutput("mid-scan reset rtck", bus.rtck, 1'b0);
        tckCycle(1'b0, 1'b0, d);
        v = '{1'b0, 4'h1, 8'h00, 64'h0, 32, 0, 64'(IDCODE), 8'h00};
        applyStimulus(v, "post-reset idcode", 8'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
